// File: rtl/fetch_if.sv
// fetch_if: handshake/bus bundle between the fetch stage and its neighbours
// (hazard unit, ID-stage branch/jump resolution, instruction memory and the
// decode stage).
//   master : driven by the surrounding pipeline (control and memory side)
//   slave  : used by fetch_stage
// Signals:
//   stall, pc_src, pc_jump          hazard/redirect controls
//   branch_target[31:0]             branch destination from ID
//   jump_index[25:0]                instr[25:0] of the jump in ID
//   imem_rdata[31:0]                instruction word at imem_addr (combinational)
//   imem_addr[31:0]                 current PC
//   if_id_instr, if_id_pc_plus4     IF/ID pipeline register contents
//   if_id_valid                     1 = real instruction, 0 = bubble
// Optional macro FETCH_PERF_CNT_EN adds fetch_count and flush_count.
interface fetch_if;
    logic        stall;
    logic        pc_src;
    logic        pc_jump;
    logic [31:0] branch_target;
    logic [25:0] jump_index;
    logic [31:0] imem_rdata;
    logic [31:0] imem_addr;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_pc_plus4;
    logic        if_id_valid;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_count;
    logic [31:0] flush_count;
`endif

    modport master (
        output stall, pc_src, pc_jump, branch_target, jump_index, imem_rdata,
        input  imem_addr, if_id_instr, if_id_pc_plus4, if_id_valid
`ifdef FETCH_PERF_CNT_EN
        , input fetch_count, flush_count
`endif
    );

    modport slave (
        input  stall, pc_src, pc_jump, branch_target, jump_index, imem_rdata,
        output imem_addr, if_id_instr, if_id_pc_plus4, if_id_valid
`ifdef FETCH_PERF_CNT_EN
        , output fetch_count, flush_count
`endif
    );
endinterface

// File: rtl/fetch_stage.sv
// fetch_stage: MIPS instruction-fetch stage plus IF/ID pipeline register.
// Holds the PC, drives imem_addr, selects the next PC (jump > branch >
// stall > sequential) and loads/holds/flushes the IF/ID register.
// Ports:
//   clk  - rising-edge clock
//   rst  - synchronous, active-high reset
//   bus  - fetch_if.slave (controls, imem interface, IF/ID outputs)
// Parameters:
//   RESET_PC  - PC loaded on reset
//   NOP_INSTR - word injected into IF/ID on reset and flush
// Optional macro FETCH_PERF_CNT_EN: adds fetch_count (valid IF/ID loads)
// and flush_count (redirect cycles), both wrapping 32-bit counters.
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input logic   clk,
    input logic   rst,
    fetch_if.slave bus
);
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [31:0] jump_target;
    logic [31:0] redirect_pc;
    logic        redirect;

    assign bus.imem_addr = pc;
    assign pc_plus4      = pc + 32'd4;
    // Upper PC bits come from the jump's own PC+4 (now in ID), not the
    // current fetch PC, which may already lie in another 256 MB region.
    assign jump_target   = {bus.if_id_pc_plus4[31:28], bus.jump_index, 2'b00};
    assign redirect      = bus.pc_jump | bus.pc_src;
    assign redirect_pc   = bus.pc_jump ? jump_target
                                       : {bus.branch_target[31:2], 2'b00};

    // Redirect takes precedence over stall: the wrong-path word is dropped
    // and a bubble enters ID even if the hazard unit asked to hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc                 <= RESET_PC;
            bus.if_id_instr    <= NOP_INSTR;
            bus.if_id_pc_plus4 <= RESET_PC;
            bus.if_id_valid    <= 1'b0;
        end else if (redirect) begin
            pc                 <= redirect_pc;
            bus.if_id_instr    <= NOP_INSTR;
            bus.if_id_pc_plus4 <= pc_plus4;
            bus.if_id_valid    <= 1'b0;
        end else if (!bus.stall) begin
            pc                 <= pc_plus4;
            bus.if_id_instr    <= bus.imem_rdata;
            bus.if_id_pc_plus4 <= pc_plus4;
            bus.if_id_valid    <= 1'b1;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.fetch_count <= 32'd0;
            bus.flush_count <= 32'd0;
        end else if (redirect) begin
            bus.flush_count <= bus.flush_count + 32'd1;
        end else if (!bus.stall) begin
            bus.fetch_count <= bus.fetch_count + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fetch_if bus ();
    fetch_stage #(.RESET_PC(32'h0000_0000), .NOP_INSTR(32'h0000_0000)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Instruction memory: word at address a is {16'hC0DE, a[15:0]}.
    assign bus.imem_rdata = {16'hC0DE, bus.imem_addr[15:0]};

    typedef struct {
        string       name;
        logic [31:0] addr;
        logic [31:0] instr;
        logic [31:0] pc4;
        logic        valid;
        logic        chk_cnt;
        logic [31:0] fcnt;
        logic [31:0] flcnt;
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;

    task automatic cmp(input string name, input string fld,
                       input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s.%s: got %h expected %h", name, fld, act, exp);
        end
    endtask

    // Monitor: after each rising edge, pop the expectation issued for it.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                exp_t e;
                e = q.pop_front();
                cmp(e.name, "imem_addr", bus.imem_addr, e.addr);
                cmp(e.name, "if_id_instr", bus.if_id_instr, e.instr);
                cmp(e.name, "if_id_pc_plus4", bus.if_id_pc_plus4, e.pc4);
                cmp(e.name, "if_id_valid", {31'd0, bus.if_id_valid}, {31'd0, e.valid});
`ifdef FETCH_PERF_CNT_EN
                if (e.chk_cnt) begin
                    cmp(e.name, "fetch_count", bus.fetch_count, e.fcnt);
                    cmp(e.name, "flush_count", bus.flush_count, e.flcnt);
                end
`endif
            end
        end
    end

    // One cycle of stimulus plus the hand-computed state after the edge.
    task automatic step(input string name, input logic r, input logic st,
                        input logic src, input logic jmp,
                        input logic [31:0] bt, input logic [25:0] ji,
                        input logic [31:0] ea, input logic [31:0] ei,
                        input logic [31:0] ep, input logic ev,
                        input logic cc = 1'b0, input logic [31:0] fc = 0,
                        input logic [31:0] fl = 0);
        exp_t e;
        @(negedge clk);
        rst               = r;
        bus.stall         = st;
        bus.pc_src        = src;
        bus.pc_jump       = jmp;
        bus.branch_target = bt;
        bus.jump_index    = ji;
        e.name = name; e.addr = ea; e.instr = ei; e.pc4 = ep; e.valid = ev;
        e.chk_cnt = cc; e.fcnt = fc; e.flcnt = fl;
        q.push_back(e);
    endtask

    initial begin
        rst = 1'b1; bus.stall = 0; bus.pc_src = 0; bus.pc_jump = 0;
        bus.branch_target = 0; bus.jump_index = 0;

        //    name       rst st src jmp bt            ji        addr          instr         pc4           v
        step("reset0",   1, 0, 0, 0, 32'h0,        26'h0,    32'h0,        32'h0,        32'h0,        0, 1'b1, 0, 0);
        step("reset1",   1, 1, 1, 1, 32'h80,       26'h5,    32'h0,        32'h0,        32'h0,        0);
        // sequential fetch
        step("seq0",     0, 0, 0, 0, 32'h0,        26'h0,    32'h4,        32'hC0DE0000, 32'h4,        1);
        step("seq1",     0, 0, 0, 0, 32'h0,        26'h0,    32'h8,        32'hC0DE0004, 32'h8,        1);
        // stall at PC=8
        for (int i = 0; i < 3; i++)
            step("stall",0, 1, 0, 0, 32'h0,        26'h0,    32'h8,        32'hC0DE0004, 32'h8,        1);
        step("resume",   0, 0, 0, 0, 32'h0,        26'h0,    32'hC,        32'hC0DE0008, 32'hC,        1);
        step("seq2",     0, 0, 0, 0, 32'h0,        26'h0,    32'h10,       32'hC0DE000C, 32'h10,       1);
        // branch with unaligned target
        step("branch",   0, 0, 1, 0, 32'h43,       26'h0,    32'h40,       32'h0,        32'h14,       0);
        step("br_fetch", 0, 0, 0, 0, 32'h0,        26'h0,    32'h44,       32'hC0DE0040, 32'h44,       1);
        // set up if_id_pc_plus4 = 1000_0010, then jump during stall
        step("br_hi",    0, 0, 1, 0, 32'h1000000C, 26'h0,    32'h1000000C, 32'h0,        32'h48,       0);
        step("seq_hi",   0, 0, 0, 0, 32'h0,        26'h0,    32'h10000010, 32'hC0DE000C, 32'h10000010, 1);
        step("jmp_stl",  0, 1, 0, 1, 32'h0,        26'h100,  32'h10000400, 32'h0,        32'h10000014, 0);
        step("jmp_fet",  0, 0, 0, 0, 32'h0,        26'h0,    32'h10000404, 32'hC0DE0400, 32'h10000404, 1);
        // jump and branch together: jump wins
        step("jmp_br",   0, 0, 1, 1, 32'h80,       26'h3,    32'h1000000C, 32'h0,        32'h10000408, 0);
        // redirect while IF/ID holds a bubble still executes
        step("br_bub",   0, 0, 1, 0, 32'h20,       26'h0,    32'h20,       32'h0,        32'h10000010, 0);
        // wrap at top of address space
        step("br_top",   0, 0, 1, 0, 32'hFFFFFFFF, 26'h0,    32'hFFFFFFFC, 32'h0,        32'h24,       0);
        step("wrap",     0, 0, 0, 0, 32'h0,        26'h0,    32'h0,        32'hC0DEFFFC, 32'h0,        1);
        step("post_wr",  0, 0, 0, 0, 32'h0,        26'h0,    32'h4,        32'hC0DE0000, 32'h4,        1);
        step("stall2",   0, 1, 0, 0, 32'h0,        26'h0,    32'h4,        32'hC0DE0000, 32'h4,        1);
        // reset mid-stall with a pending branch
        step("rst_mid",  1, 1, 1, 0, 32'h200,      26'h0,    32'h0,        32'h0,        32'h0,        0, 1'b1, 0, 0);
        step("restart",  0, 0, 0, 0, 32'h0,        26'h0,    32'h4,        32'hC0DE0000, 32'h4,        1);
        // perf counters: reset, 5 fetches, 2 stalls, 1 redirect
        step("pc_rst",   1, 0, 0, 0, 32'h0,        26'h0,    32'h0,        32'h0,        32'h0,        0, 1'b1, 0, 0);
        step("pc_f1",    0, 0, 0, 0, 32'h0,        26'h0,    32'h4,        32'hC0DE0000, 32'h4,        1);
        step("pc_f2",    0, 0, 0, 0, 32'h0,        26'h0,    32'h8,        32'hC0DE0004, 32'h8,        1);
        step("pc_f3",    0, 0, 0, 0, 32'h0,        26'h0,    32'hC,        32'hC0DE0008, 32'hC,        1);
        step("pc_f4",    0, 0, 0, 0, 32'h0,        26'h0,    32'h10,       32'hC0DE000C, 32'h10,       1);
        step("pc_f5",    0, 0, 0, 0, 32'h0,        26'h0,    32'h14,       32'hC0DE0010, 32'h14,       1, 1'b1, 5, 0);
        step("pc_s1",    0, 1, 0, 0, 32'h0,        26'h0,    32'h14,       32'hC0DE0010, 32'h14,       1);
        step("pc_s2",    0, 1, 0, 0, 32'h0,        26'h0,    32'h14,       32'hC0DE0010, 32'h14,       1, 1'b1, 5, 0);
        step("pc_redir", 0, 0, 1, 0, 32'h100,      26'h0,    32'h100,      32'h0,        32'h18,       0, 1'b1, 5, 1);

        @(negedge clk);
        bus.pc_src = 0; bus.stall = 1;
        // Bounded drain of outstanding expectations.
        for (int i = 0; i < 20 && q.size() > 0; i++) @(negedge clk);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, expected 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
